ps2_tx: RTL and testbench



---
 rtl/ps2_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: sends one command byte using the open-drain
// host request sequence and reports completion or failure with one-cycle pulses.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FW = 10;
  localparam int unsigned EW = 4;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic [EW-1:0] ecnt;
  logic [FW-1:0] frame;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic fe;
  logic timeout_hit;
  logic [TW-1:0] tcnt_inc;

  // Two-flop synchronizers; idle-high reset values avoid a spurious edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_i;
      data_sync <= data_meta;
    end
  end

  assign fe          = clk_prev & ~clk_sync;
  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign tcnt_inc    = (tcnt == '1) ? tcnt : tcnt + TW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      icnt        <= '0;
      tcnt        <= '0;
      ecnt        <= '0;
      frame       <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_valid && tx_ready) begin
            frame      <= {1'b1, ~^tx_data, tx_data};
            icnt       <= '0;
            tx_ready   <= 1'b0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end else begin
            // Ready returns one cycle after a done/err pulse.
            tx_ready <= 1'b1;
          end
        end

        INHIBIT: begin
          if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;
            state       <= START;
          end else begin
            icnt <= icnt + IW'(1);
          end
        end

        START: begin
          ps2_clk_oe <= 1'b0;
          tcnt       <= '0;
          ecnt       <= '0;
          state      <= SEND;
        end

        SEND: begin
          if (fe) begin
            tcnt <= '0;
            if (ecnt == EW'(10)) begin
              // Eleventh falling edge: device ack is a low data line.
              ps2_data_oe <= 1'b0;
              if (data_sync) begin
                tx_err <= 1'b1;
                state  <= IDLE;
              end else begin
                state <= WAIT_IDLE;
              end
            end else begin
              ps2_data_oe <= ~frame[0];
              frame       <= {1'b1, frame[FW-1:1]};
              ecnt        <= ecnt + EW'(1);
            end
          end else if (timeout_hit) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end

        WAIT_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (clk_sync && data_sync) begin
            tx_done <= 1'b1;
            state   <= IDLE;
          end else if (timeout_hit) begin
            tx_err <= 1'b1;
            state  <= IDLE;
          end else begin
            tcnt <= tcnt_inc;
          end
        end

        default: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain line model and a simple
// keyboard model that clocks at 10 kHz against a 1 MHz system clock.
module tb_ps2_tx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       dev_clk;
  logic       dev_data;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ps2_tx #(.INHIBIT_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  // Wired-AND open-drain lines with pull-ups.
  assign ps2_clk_i  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_i = ~ps2_data_oe & dev_data;

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_err === 1'b1) err_cnt++;
      if (tx_done === 1'b1 && tx_err === 1'b1) both_cnt++;
    end
  end

  task automatic request(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Counts clock-inhibit cycles, leaving the bench on the first cycle that differs.
  task automatic measure_inhibit(output int n, output logic start_ok);
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    start_ok = (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1);
  endtask

  // Keyboard model: samples start, data, parity, stop after each rising edge.
  task automatic dev_frame(input int stop_after, input logic ack,
                           output logic [10:0] bits, output logic ok);
    int w = 0;
    ok   = 1'b1;
    bits = '0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      ok = 1'b0;
      return;
    end
    repeat (50) @(negedge clk);
    bits[0] = ps2_data_i;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      if (k == stop_after) return;
      repeat (50) @(negedge clk);
      dev_clk = 1'b1;
      repeat (25) @(negedge clk);
      bits[k] = ps2_data_i;
      repeat (25) @(negedge clk);
    end
    if (ack) dev_data = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (50) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_ready(output logic ok);
    int w = 0;
    while (tx_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    ok = (tx_ready === 1'b1);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset tx_ready: got %b want 1", tx_ready); end
    tests++; if (tx_done !== 1'b0 || tx_err !== 1'b0) begin fails++; $display("FAIL reset pulses: done=%b err=%b want 0 0", tx_done, tx_err); end
    tests++; if (ps2_clk_oe !== 1'b0) begin fails++; $display("FAIL reset clk_oe: got %b want 0", ps2_clk_oe); end
    tests++; if (ps2_data_oe !== 1'b0) begin fails++; $display("FAIL reset data_oe: got %b want 0", ps2_data_oe); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_normal;
    int n; logic st, ok, rdy; logic [10:0] bits; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    request(8'hED);
    measure_inhibit(n, st);
    tests++; if (n !== 16) begin fails++; $display("FAIL normal inhibit cycles: got %0d want 16", n); end
    tests++; if (st !== 1'b1) begin fails++; $display("FAIL normal start cycle: clk_oe=%b data_oe=%b want 1 1", ps2_clk_oe, ps2_data_oe); end
    @(negedge clk);
    tests++; if (ps2_clk_oe !== 1'b0) begin fails++; $display("FAIL normal start length: clk_oe=%b want 0", ps2_clk_oe); end
    dev_frame(0, 1'b1, bits, ok);
    tests++; if (ok !== 1'b1 || bits !== 11'h7DA) begin fails++; $display("FAIL normal ED bits: got %h want 7da", bits); end
    wait_ready(rdy);
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL normal ready: got %b want 1", tx_ready); end
    tests++; if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin fails++; $display("FAIL normal pulses: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0); end
  endtask

  task automatic test_parity;
    int n; logic st, ok, rdy; logic [10:0] bits; int d0;
    d0 = done_cnt;
    request(8'h00);
    measure_inhibit(n, st);
    dev_frame(0, 1'b1, bits, ok);
    tests++; if (ok !== 1'b1 || bits !== 11'h600) begin fails++; $display("FAIL parity 00 bits: got %h want 600", bits); end
    wait_ready(rdy);
    request(8'h01);
    measure_inhibit(n, st);
    dev_frame(0, 1'b1, bits, ok);
    tests++; if (ok !== 1'b1 || bits !== 11'h402) begin fails++; $display("FAIL parity 01 bits: got %h want 402", bits); end
    wait_ready(rdy);
    tests++; if (rdy !== 1'b1 || done_cnt - d0 !== 2) begin fails++; $display("FAIL parity done: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_nack;
    int n; logic st, ok, rdy; logic [10:0] bits; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    request(8'h55);
    measure_inhibit(n, st);
    dev_frame(0, 1'b0, bits, ok);
    tests++; if (ok !== 1'b1 || bits !== 11'h6AA) begin fails++; $display("FAIL nack bits: got %h want 6aa", bits); end
    wait_ready(rdy);
    tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL nack ready: got %b want 1", tx_ready); end
    tests++; if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin fails++; $display("FAIL nack pulses: err %0d done %0d want 1 0", err_cnt - e0, done_cnt - d0); end
  endtask

  task automatic test_timeout;
    int n, w; logic st, ok, rdy; logic [10:0] bits; int d0;
    d0 = done_cnt;
    request(8'h3C);
    measure_inhibit(n, st);
    dev_frame(4, 1'b1, bits, ok);
    w = 0;
    while (tx_err !== 1'b1 && w < 1100) begin
      @(negedge clk);
      w++;
    end
    // Pin fall to registered fe is 3 cycles, then 1000 cycles of timeout.
    tests++; if (w !== 1003) begin fails++; $display("FAIL timeout latency: got %0d want 1003", w); end
    tests++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin fails++; $display("FAIL timeout release: clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    @(negedge clk);
    tests++; if (tx_err !== 1'b0 || tx_ready !== 1'b1) begin fails++; $display("FAIL timeout pulse end: err=%b ready=%b want 0 1", tx_err, tx_ready); end
    dev_clk = 1'b1;
    wait_ready(rdy);
    tests++; if (rdy !== 1'b1 || done_cnt - d0 !== 0) begin fails++; $display("FAIL timeout done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    int n, w; logic st, ok; logic [10:0] bits; int d0;
    d0 = done_cnt;
    @(negedge clk);
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'hAA;
    measure_inhibit(n, st);
    tests++; if (n !== 16 || st !== 1'b1) begin fails++; $display("FAIL b2b first inhibit: got %0d want 16", n); end
    dev_frame(0, 1'b1, bits, ok);
    tests++; if (ok !== 1'b1 || bits !== 11'h5E8) begin fails++; $display("FAIL b2b F4 bits: got %h want 5e8", bits); end
    w = 0;
    while (tx_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    tests++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin fails++; $display("FAIL b2b ready return: ready=%b clk_oe=%b want 1 0", tx_ready, ps2_clk_oe); end
    @(negedge clk);
    tests++; if (tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin fails++; $display("FAIL b2b second accept: ready=%b clk_oe=%b want 0 1", tx_ready, ps2_clk_oe); end
    tx_valid = 1'b0;
    measure_inhibit(n, st);
    dev_frame(0, 1'b1, bits, ok);
    tests++; if (ok !== 1'b1 || bits !== 11'h754) begin fails++; $display("FAIL b2b AA bits: got %h want 754", bits); end
    wait_ready(ok);
    tests++; if (ok !== 1'b1 || done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b done: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_send;
    int n; logic st; int d0, e0;
    request(8'h3C);
    measure_inhibit(n, st);
    @(negedge clk);
    dev_clk = 1'b0;
    repeat (50) @(negedge clk);
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (ps2_data_oe !== 1'b1) begin fails++; $display("FAIL midsend data_oe before reset: got %b want 1", ps2_data_oe); end
    d0 = done_cnt; e0 = err_cnt;
    #100;
    rstn = 1'b0;
    #1;
    tests++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin fails++; $display("FAIL midsend release: clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    tests++; if (tx_ready !== 1'b1 || tx_done !== 1'b0 || tx_err !== 1'b0) begin fails++; $display("FAIL midsend flags: ready=%b done=%b err=%b want 1 0 0", tx_ready, tx_done, tx_err); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || tx_ready !== 1'b1) begin fails++; $display("FAIL midsend after: done %0d err %0d ready %b want 0 0 1", done_cnt - d0, err_cnt - e0, tx_ready); end
  endtask

  task automatic test_exclusive;
    tests++; if (both_cnt !== 0) begin fails++; $display("FAIL exclusive pulses: got %0d overlaps want 0", both_cnt); end
  endtask

  initial begin
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    test_reset;
    test_normal;
    test_parity;
    test_nack;
    test_timeout;
    test_back_to_back;
    test_reset_mid_send;
    test_exclusive;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
